// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and helpers for the 4-digit display scan sequencer.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

    localparam int NUM_DIGITS  = 4;
    localparam int DIGIT_SEL_W = 8;

    // One-hot digit enable for a scan index; upper bits stay 0.
    function automatic logic [DIGIT_SEL_W-1:0] onehot_sel(input logic [1:0] idx);
        return DIGIT_SEL_W'(1) << idx;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Control/data bundle between the display scan sequencer and its user.
interface display_scan_ctrl_if;
    import disp_pkg::*;

    logic                   enable;
    logic                   load;
    logic [15:0]            bcd_in;
    logic                   lz_blank_en;
    logic [1:0]             scan_cnt;
    logic [DIGIT_SEL_W-1:0] digit_sel;
    logic [3:0]             digit_bcd;
    logic                   digit_blank;
    logic                   frame_done;

    modport master (
        output enable, load, bcd_in, lz_blank_en,
        input  scan_cnt, digit_sel, digit_bcd, digit_blank, frame_done
    );

    modport slave (
        input  enable, load, bcd_in, lz_blank_en,
        output scan_cnt, digit_sel, digit_bcd, digit_blank, frame_done
    );

endinterface

// File: rtl/display_scan_ctrl_timer.sv
// Slot timer: counts cycles since the last state entry and flags the
// last gap cycle, the last show cycle and the show cycle before that.
module scan_slot_timer #(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic gap_done,
    output logic slot_done,
    output logic slot_almost
);
    localparam int CW       = $clog2(SCAN_DIV);
    localparam int SHOW_LEN = SCAN_DIV - BLANK_CYCLES;
    localparam bit HAS_ALMOST = (SHOW_LEN >= 2);
    localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_LEN - 1);
    localparam logic [CW-1:0] SHOW_PREV = CW'(HAS_ALMOST ? SHOW_LEN - 2 : 0);

    logic [CW-1:0] cnt;

    // Free-running up-count, restarted whenever the FSM enters a state.
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else            cnt <= cnt + CW'(1);
    end

    assign gap_done    = (cnt == GAP_LAST);
    assign slot_done   = (cnt == SHOW_LAST);
    assign slot_almost = HAS_ALMOST && (cnt == SHOW_PREV);

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit 7-segment scan sequencer: tear-free shadow of the BCD value,
// per-slot blanking gap, leading-zero blanking, frame_done pulse.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input logic              clk,
    input logic              rst,
    display_scan_ctrl_if.slave bus
);
    localparam int SHOW_LEN = SCAN_DIV - BLANK_CYCLES;

    scan_state_t            state;
    logic [1:0]             scan_cnt;
    logic [DIGIT_SEL_W-1:0] digit_sel;
    logic [3:0]             digit_bcd;
    logic                   digit_blank;
    logic                   frame_done;

    logic [15:0] shadow, pending;
    logic        pend;
    logic [15:0] shadow_nxt, pending_nxt;
    logic        pend_nxt;
    logic        frame_end, timer_clr, hide;
    logic        gap_done, slot_done, slot_almost;
    logic [1:0]  scan_inc;

    function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    return v[3:0];
            2'd1:    return v[7:4];
            2'd2:    return v[11:8];
            default: return v[15:12];
        endcase
    endfunction

    // Only literal 0 counts as a leading zero; A-F never do.
    function automatic logic lz_hidden(input logic [15:0] v, input logic [1:0] idx);
        case (idx)
            2'd3:    return v[15:12] == 4'd0;
            2'd2:    return v[15:8]  == 8'd0;
            2'd1:    return v[15:4]  == 12'd0;
            default: return 1'b0;
        endcase
    endfunction

    scan_slot_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clr         (timer_clr),
        .gap_done    (gap_done),
        .slot_done   (slot_done),
        .slot_almost (slot_almost)
    );

    assign scan_inc  = scan_cnt + 2'd1;
    assign frame_end = (state == SHOW) && slot_done && (scan_cnt == 2'd3);
    assign timer_clr = !bus.enable || (state == IDLE)
                     || ((state == BLANK) && gap_done)
                     || ((state == SHOW)  && slot_done);
    assign hide      = bus.lz_blank_en && lz_hidden(shadow_nxt, scan_cnt);

    // Load path: shadow only changes at a frame boundary or while idle.
    always_comb begin
        shadow_nxt  = shadow;
        pending_nxt = pending;
        pend_nxt    = pend;
        if (state == IDLE) begin
            if (bus.load) begin
                shadow_nxt = bus.bcd_in;
                pend_nxt   = 1'b0;
            end
        end else if (frame_end) begin
            pend_nxt = 1'b0;
            if (bus.load)  shadow_nxt = bus.bcd_in;
            else if (pend) shadow_nxt = pending;
        end else if (bus.load) begin
            pending_nxt = bus.bcd_in;
            pend_nxt    = 1'b1;
        end
    end

    // Shadow/pending registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            pending <= '0;
            pend    <= 1'b0;
        end else begin
            shadow  <= shadow_nxt;
            pending <= pending_nxt;
            pend    <= pend_nxt;
        end
    end

    // Scan FSM with registered digit outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            scan_cnt    <= 2'd0;
            digit_sel   <= '0;
            digit_bcd   <= 4'd0;
            digit_blank <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            digit_sel   <= '0;
            digit_blank <= 1'b1;
            frame_done  <= 1'b0;
            if (!bus.enable) begin
                state     <= IDLE;
                scan_cnt  <= 2'd0;
                digit_bcd <= nibble(shadow_nxt, 2'd0);
            end else begin
                case (state)
                    IDLE: begin
                        state     <= BLANK;
                        scan_cnt  <= 2'd0;
                        digit_bcd <= nibble(shadow_nxt, 2'd0);
                    end
                    BLANK: begin
                        digit_bcd <= nibble(shadow_nxt, scan_cnt);
                        if (gap_done) begin
                            state       <= SHOW;
                            digit_sel   <= hide ? '0 : onehot_sel(scan_cnt);
                            digit_blank <= hide;
                            frame_done  <= (SHOW_LEN == 1) && (scan_cnt == 2'd3);
                        end
                    end
                    SHOW: begin
                        if (slot_done) begin
                            state     <= BLANK;
                            scan_cnt  <= scan_inc;
                            digit_bcd <= nibble(shadow_nxt, scan_inc);
                        end else begin
                            digit_bcd   <= nibble(shadow_nxt, scan_cnt);
                            digit_sel   <= hide ? '0 : onehot_sel(scan_cnt);
                            digit_blank <= hide;
                            frame_done  <= slot_almost && (scan_cnt == 2'd3);
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        scan_cnt <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign bus.scan_cnt    = scan_cnt;
    assign bus.digit_sel   = digit_sel;
    assign bus.digit_bcd   = digit_bcd;
    assign bus.digit_blank = digit_blank;
    assign bus.frame_done  = frame_done;

endmodule
